// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the shared-ALU controller slice:
//   - default operand/result and opcode widths
//   - ALU opcode encoding (the controller forwards these untouched)
//   - controller FSM state encoding and settle-counter width
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int OPW_DEF   = 3;

  // Settle counter holds SETTLE_CYCLES-1, and SETTLE_CYCLES is at most 15.
  localparam int CNT_W = 4;

  localparam logic [OPW_DEF-1:0] OP_ADD = 3'd0;
  localparam logic [OPW_DEF-1:0] OP_SUB = 3'd1;
  localparam logic [OPW_DEF-1:0] OP_AND = 3'd2;
  localparam logic [OPW_DEF-1:0] OP_OR  = 3'd3;
  localparam logic [OPW_DEF-1:0] OP_XOR = 3'd4;
  localparam logic [OPW_DEF-1:0] OP_NOT = 3'd5;
  localparam logic [OPW_DEF-1:0] OP_SLL = 3'd6;
  localparam logic [OPW_DEF-1:0] OP_SRL = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl_if
// Bundles every non-clock signal of alu_share_ctrl:
//   req0_* / req1_* : valid/ready request channels carrying op, a, b
//   alu_a/b/op      : registered operands and select towards the shared ALU
//   alu_s           : combinational ALU result back into the controller
//   rsp_*           : single valid/ready response channel tagged with rsp_id
// Modports: slave = controller side, master = requesters/ALU/consumer side.
// -----------------------------------------------------------------------------
interface alu_share_ctrl_if
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF
);

  logic             req0_valid;
  logic             req0_ready;
  logic [OPW-1:0]   req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_s;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_s, rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_op,
    output rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_s, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/alu_share_ctrl_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter, purely combinational.
//   valid[1:0]  : request lines (bit N = requester N)
//   last_grant  : requester that won the previous accepted operation
//   grant[1:0]  : one-hot grant, all-zero when nobody requests
// A lone requester always wins; on a tie the requester that did not win
// last time gets the grant.
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven,
    // so no latch is inferred for grant.
    grant = 2'b00;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl
// Time-shares one combinational ALU between two requesters.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : alu_share_ctrl_if.slave - two request channels, ALU operand/select
//          outputs, ALU result input, tagged response channel
// Flow: IDLE grants one requester (round robin) and registers its op/a/b onto
// the ALU inputs; SETTLE waits SETTLE_CYCLES edges for the gate chain to
// resolve and captures alu_s; RESP holds the tagged result until rsp_ready.
// Operands and opcode are passed through unmodified.
// -----------------------------------------------------------------------------
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEF,
  parameter int SETTLE_CYCLES = 2,
  parameter int OPW           = OPW_DEF
) (
  input logic             clk,
  input logic             rst,
  alu_share_ctrl_if.slave bus
);

  // Loaded on accept so that the capture lands exactly SETTLE_CYCLES edges
  // after the accept edge (counter hits zero on the last of those edges).
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  ctrl_state_e      state_q;
  ctrl_state_e      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             last_grant_q;
  logic [1:0]       grant;
  logic             sel;
  logic             accept;
  logic             capture;
  logic             rsp_done;

  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [OPW-1:0]   alu_op_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;

  rr_arb2 u_arb (
    .valid      ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Ready is only offered while idle, so the one-hot grant guarantees at
  // most one ready per cycle.
  assign bus.req0_ready = (state_q == IDLE) && grant[0];
  assign bus.req1_ready = (state_q == IDLE) && grant[1];
  assign sel            = grant[1];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    capture  = 1'b0;
    rsp_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          accept  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        // rsp_valid is always high here, so rsp_ready alone completes it.
        if (bus.rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: ALU operand latch, settle counter, response holder
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      if (accept) begin
        alu_a_q      <= sel ? bus.req1_a  : bus.req0_a;
        alu_b_q      <= sel ? bus.req1_b  : bus.req0_b;
        alu_op_q     <= sel ? bus.req1_op : bus.req0_op;
        last_grant_q <= sel;
        rsp_id_q     <= sel;
        cnt_q        <= CNT_LOAD;
      end else if (state_q == SETTLE && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end

      if (capture) begin
        rsp_data_q  <= bus.alu_s;
        rsp_valid_q <= 1'b1;
      end else if (rsp_done) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_share_ctrl
// Two controller instances: dut0 with SETTLE_CYCLES=2 (main tests) and dut1
// with SETTLE_CYCLES=1. Each sees a behavioural ALU that returns a poison
// value until its inputs have been stable long enough, so an early capture
// shows up as wrong data. dut0 responses are checked by a scoreboard whose
// entries are computed from the requester payload at each handshake.
// -----------------------------------------------------------------------------
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int S0 = 2;
  localparam int S1 = 1;
  localparam logic [W-1:0] POISON = 32'hDEAD_BEEF;

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t exp_q[$];

  alu_share_ctrl_if #(.WIDTH(W), .OPW(OPW_DEF)) bus  ();
  alu_share_ctrl_if #(.WIDTH(W), .OPW(OPW_DEF)) bus1 ();

  alu_share_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S0), .OPW(OPW_DEF)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  alu_share_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S1), .OPW(OPW_DEF)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] alu_ref(input logic [2:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOT:  return ~a;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      default: return '0;
    endcase
  endfunction

  // Behavioural ALU with settling: result valid only once the inputs have
  // been stable for SETTLE-1 negedges, poison otherwise.
  logic [W-1:0] p0_a, p0_b, p1_a, p1_b;
  logic [2:0]   p0_op, p1_op;
  int           stable0 = 0;
  int           stable1 = 0;

  always @(negedge clk) begin
    if (bus.alu_a !== p0_a || bus.alu_b !== p0_b || bus.alu_op !== p0_op) begin
      stable0 <= 0;
      p0_a    <= bus.alu_a;
      p0_b    <= bus.alu_b;
      p0_op   <= bus.alu_op;
    end else if (stable0 < 100) begin
      stable0 <= stable0 + 1;
    end
    if (bus1.alu_a !== p1_a || bus1.alu_b !== p1_b || bus1.alu_op !== p1_op) begin
      stable1 <= 0;
      p1_a    <= bus1.alu_a;
      p1_b    <= bus1.alu_b;
      p1_op   <= bus1.alu_op;
    end else if (stable1 < 100) begin
      stable1 <= stable1 + 1;
    end
  end

  assign bus.alu_s  = (stable0 >= S0 - 1) ? alu_ref(bus.alu_op, bus.alu_a, bus.alu_b) : POISON;
  assign bus1.alu_s = (stable1 >= S1 - 1) ? alu_ref(bus1.alu_op, bus1.alu_a, bus1.alu_b) : POISON;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Request-side monitor: one-hot ready, and scoreboard push on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req0_ready || bus.req1_ready)
        check("ready_excl", {63'd0, bus.req0_ready & bus.req1_ready}, 64'd0);
      if (bus.req0_valid && bus.req0_ready)
        exp_q.push_back('{id: 1'b0, data: alu_ref(bus.req0_op, bus.req0_a, bus.req0_b)});
      if (bus.req1_valid && bus.req1_ready)
        exp_q.push_back('{id: 1'b1, data: alu_ref(bus.req1_op, bus.req1_a, bus.req1_b)});
    end
  end

  // Response-side monitor: pop and compare on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", {63'd0, bus.rsp_id}, {63'd0, e.id});
        check("rsp_data", 64'(bus.rsp_data), 64'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 40 && exp_q.size() != 0; t++) @(negedge clk);
    #1;
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_rsp(input string tag, output int at);
    at = -1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        at = cyc;
        break;
      end
    end
    check(tag, {63'd0, bus.rsp_valid}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    int      acc, rise, prev;
    bit      got;
    logic    id, other;
    logic [W-1:0] d0;
    logic    i0;

    rst = 1'b1;
    bus.req0_valid = 0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready  = 0;
    bus1.req0_valid = 0; bus1.req0_op = '0; bus1.req0_a = '0; bus1.req0_b = '0;
    bus1.req1_valid = 0; bus1.req1_op = '0; bus1.req1_a = '0; bus1.req1_b = '0;
    bus1.rsp_ready  = 0;

    // ---- reset state --------------------------------------------------------
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_alu_a",     64'(bus.alu_a), 64'd0);
    check("rst_alu_b",     64'(bus.alu_b), 64'd0);
    check("rst_alu_op",    64'(bus.alu_op), 64'd0);
    check("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    check("rst_rsp_id",    {63'd0, bus.rsp_id}, 64'd0);
    check("rst_rsp_data",  64'(bus.rsp_data), 64'd0);
    check("rst1_rsp_valid", {63'd0, bus1.rsp_valid}, 64'd0);
    check("rst1_rsp_data",  64'(bus1.rsp_data), 64'd0);
    tick();
    rst = 1'b0;

    // ---- single request: OR on requester 0 ----------------------------------
    bus.rsp_ready  = 1;
    bus.req0_valid = 1;
    bus.req0_op    = OP_OR;
    bus.req0_a     = 32'h0000_F0F0;
    bus.req0_b     = 32'h0F0F_0000;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = bus.req0_ready;
    end
    check("t1_ready0", {63'd0, bus.req0_ready}, 64'd1);
    acc = cyc;
    tick();  // accept edge; valid kept high to show ready is a single pulse
    @(negedge clk);
    check("t1_ready_pulse", {63'd0, bus.req0_ready}, 64'd0);
    check("t1_alu_a",  64'(bus.alu_a), 64'h0000_F0F0);
    check("t1_alu_b",  64'(bus.alu_b), 64'h0F0F_0000);
    check("t1_alu_op", 64'(bus.alu_op), 64'(OP_OR));
    tick();
    bus.req0_valid = 0;
    wait_rsp("t1_rsp_seen", rise);
    // Handshake sampled in cycle acc, accept edge is acc+1, capture S0 later.
    check("t1_latency",  64'(rise - acc), 64'(S0 + 1));
    check("t1_rsp_id",   {63'd0, bus.rsp_id}, 64'd0);
    check("t1_rsp_data", 64'(bus.rsp_data), 64'h0F0F_F0F0);
    drain("t1_drain");

    // ---- contention after reset: alternate 0,1,0,1 with S0+2 spacing --------
    tick();
    rst = 1;
    tick();
    rst = 0;
    bus.req0_valid = 1; bus.req0_op = OP_ADD; bus.req0_a = 32'h7FFF_FFFF; bus.req0_b = 32'd1;
    bus.req1_valid = 1; bus.req1_op = OP_SUB; bus.req1_a = 32'd0;         bus.req1_b = 32'd1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk);
        got = bus.req0_ready | bus.req1_ready;
      end
      check("t2_accept", {63'd0, got}, 64'd1);
      id = bus.req1_ready;
      check("t2_grant", {63'd0, id}, 64'(k % 2));
      if (k > 0) check("t2_spacing", 64'(cyc - prev), 64'(S0 + 2));
      prev = cyc;
      tick();
      if (id) begin
        bus.req1_op = 3'($urandom_range(0, 7));
        bus.req1_a  = $urandom;
        bus.req1_b  = $urandom;
      end else begin
        bus.req0_op = 3'($urandom_range(0, 7));
        bus.req0_a  = $urandom;
        bus.req0_b  = $urandom;
      end
    end
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    drain("t2_drain");

    // ---- backpressure: rsp_ready low for 5 cycles ---------------------------
    tick();
    bus.rsp_ready  = 0;
    bus.req0_valid = 1; bus.req0_op = OP_SLL; bus.req0_a = 32'h8000_0001; bus.req0_b = 32'd31;
    bus.req1_valid = 1; bus.req1_op = OP_NOT; bus.req1_a = 32'h1234_5678; bus.req1_b = 32'd0;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = bus.req0_ready | bus.req1_ready;
    end
    check("t3_accept", {63'd0, got}, 64'd1);
    id    = bus.req1_ready;
    other = ~id;
    tick();
    if (id) bus.req1_valid = 0;
    else    bus.req0_valid = 0;
    wait_rsp("t3_rsp_seen", rise);
    d0 = bus.rsp_data;
    i0 = bus.rsp_id;
    check("t3_rsp_id_tag", {63'd0, i0}, {63'd0, id});
    for (int t = 0; t < 5; t++) begin
      if (t > 0) @(negedge clk);
      check("t3_hold_valid", {63'd0, bus.rsp_valid}, 64'd1);
      check("t3_hold_data",  64'(bus.rsp_data), 64'(d0));
      check("t3_hold_id",    {63'd0, bus.rsp_id}, {63'd0, i0});
      check("t3_no_ready",   {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
    end
    tick();
    bus.rsp_ready = 1;
    @(negedge clk);
    check("t3_hs_valid",    {63'd0, bus.rsp_valid}, 64'd1);
    check("t3_hs_no_ready", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
    @(negedge clk);
    check("t3_next_accept", {62'd0, bus.req1_ready, bus.req0_ready},
          other ? 64'd2 : 64'd1);
    tick();
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    drain("t3_drain");

    // ---- operand hold: req1_a changes during SETTLE -------------------------
    tick();
    bus.req1_valid = 1; bus.req1_op = OP_XOR; bus.req1_a = 32'h1234_5678; bus.req1_b = 32'h0F0F_0F0F;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = bus.req1_ready;
    end
    check("t4_accept", {63'd0, got}, 64'd1);
    tick();
    bus.req1_valid = 0;
    bus.req1_a     = 32'hFFFF_FFFF;
    @(negedge clk);
    check("t4_alu_a_hold", 64'(bus.alu_a), 64'h1234_5678);
    wait_rsp("t4_rsp_seen", rise);
    check("t4_alu_a_resp", 64'(bus.alu_a), 64'h1234_5678);
    check("t4_rsp_data",   64'(bus.rsp_data), 64'h1D3B_5977);
    drain("t4_drain");

    // ---- reset mid-SETTLE ---------------------------------------------------
    tick();
    bus.req1_valid = 1; bus.req1_op = OP_ADD; bus.req1_a = 32'd5; bus.req1_b = 32'd6;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = bus.req1_ready;
    end
    check("t5_accept", {63'd0, got}, 64'd1);
    tick();  // accept edge: controller now in SETTLE
    bus.req1_valid = 0;
    rst = 1;
    exp_q.delete();
    tick();
    rst = 0;
    bus.req0_valid = 1; bus.req0_op = OP_SRL; bus.req0_a = 32'hF000_0000; bus.req0_b = 32'd4;
    bus.req1_valid = 1;
    @(negedge clk);
    check("t5_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    check("t5_alu_a",     64'(bus.alu_a), 64'd0);
    check("t5_alu_b",     64'(bus.alu_b), 64'd0);
    check("t5_alu_op",    64'(bus.alu_op), 64'd0);
    check("t5_grant0",    {62'd0, bus.req1_ready, bus.req0_ready}, 64'd1);
    tick();
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    drain("t5_drain");

    // ---- SETTLE_CYCLES=1 instance: AND --------------------------------------
    bus1.rsp_ready  = 1;
    bus1.req0_valid = 1;
    bus1.req0_op    = OP_AND;
    bus1.req0_a     = 32'hFFFF_0000;
    bus1.req0_b     = 32'h00FF_FF00;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = bus1.req0_ready;
    end
    check("t6_accept", {63'd0, got}, 64'd1);
    acc = cyc;
    tick();
    bus1.req0_valid = 0;
    rise = -1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus1.rsp_valid) begin
        rise = cyc;
        break;
      end
    end
    check("t6_rsp_seen",  {63'd0, bus1.rsp_valid}, 64'd1);
    check("t6_latency",   64'(rise - acc), 64'(S1 + 1));
    check("t6_rsp_id",    {63'd0, bus1.rsp_id}, 64'd0);
    check("t6_rsp_data",  64'(bus1.rsp_data), 64'h00FF_0000);
    @(negedge clk);
    check("t6_rsp_clear", {63'd0, bus1.rsp_valid}, 64'd0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
